// File: rtl/reg_file_alu_unit.sv
// rtl/reg_file_alu_unit.sv - 16x8 register file with fused 4-function ALU and write-back
module reg_file_alu_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic              write_enable,
  input  logic              ALUSrc,
  input  logic [1:0]        ALUControl,
  input  logic [DATA_W-1:0] immediate,
  output logic              Zero,
  output logic [DATA_W-1:0] cpu_out,
  output logic [DATA_W-1:0] ALUResult
);

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_result;

  // x0 is forced to zero at the read mux, so its storage slot never matters
  assign w_rd1   = (RA1 == '0) ? '0 : r_regs[RA1];
  assign w_rd2   = (RA2 == '0) ? '0 : r_regs[RA2];
  assign w_src_b = ALUSrc ? immediate : w_rd2;

  always_comb begin
    w_result = '0;
    case (ALUControl)
      ALU_AND: w_result = w_rd1 & w_src_b;
      ALU_OR:  w_result = w_rd1 | w_src_b;
      ALU_ADD: w_result = w_rd1 + w_src_b;
      ALU_SUB: w_result = w_rd1 - w_src_b;
      default: w_result = '0;
    endcase
  end

  assign ALUResult = w_result;
  assign Zero      = (w_result == '0);
  assign cpu_out   = w_rd2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write_enable && (WA != '0)) begin
      r_regs[WA] <= w_result;
    end
  end

endmodule

// File: tb/tb_reg_file_alu_unit.sv
// tb/tb_reg_file_alu_unit.sv - directed self-checking bench for reg_file_alu_unit
module tb_reg_file_alu_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] RA1 = '0;
  logic [3:0] RA2 = '0;
  logic [3:0] WA = '0;
  logic       write_enable = 1'b0;
  logic       ALUSrc = 1'b0;
  logic [1:0] ALUControl = 2'b10;
  logic [7:0] immediate = '0;
  logic       Zero;
  logic [7:0] cpu_out;
  logic [7:0] ALUResult;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  reg_file_alu_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .RA1(RA1),
    .RA2(RA2),
    .WA(WA),
    .write_enable(write_enable),
    .ALUSrc(ALUSrc),
    .ALUControl(ALUControl),
    .immediate(immediate),
    .Zero(Zero),
    .cpu_out(cpu_out),
    .ALUResult(ALUResult)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [7:0] val);
    RA1 = 4'd0;
    ALUSrc = 1'b1;
    immediate = val;
    ALUControl = OP_ADD;
    WA = addr;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin
    // 1: reset, all registers read zero
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ALUSrc = 1'b1;
    immediate = 8'd0;
    ALUControl = OP_ADD;
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      RA2 = 4'(i);
      #1;
      check($sformatf("rst_res_%0d", i), 32'(ALUResult), 32'd0);
      check($sformatf("rst_zero_%0d", i), 32'(Zero), 32'd1);
      check($sformatf("rst_out_%0d", i), 32'(cpu_out), 32'd0);
    end

    // 2: write i into xi, read back
    for (int i = 1; i < 16; i++) begin
      write_reg(4'(i), 8'(i));
      RA1 = 4'(i);
      RA2 = 4'(i);
      ALUSrc = 1'b1;
      immediate = 8'd0;
      ALUControl = OP_ADD;
      #1;
      check($sformatf("wr_res_%0d", i), 32'(ALUResult), 32'(i));
      check($sformatf("wr_out_%0d", i), 32'(cpu_out), 32'(i));
      check($sformatf("wr_zero_%0d", i), 32'(Zero), 32'd0);
    end

    // 3: write to x0 is ignored
    write_reg(4'd0, 8'h55);
    RA1 = 4'd0;
    RA2 = 4'd0;
    ALUSrc = 1'b1;
    immediate = 8'd0;
    ALUControl = OP_ADD;
    #1;
    check("x0_res", 32'(ALUResult), 32'd0);
    check("x0_out", 32'(cpu_out), 32'd0);
    check("x0_zero", 32'(Zero), 32'd1);

    // 4: register-register ADD/SUB with wrap
    write_reg(4'd1, 8'd200);
    write_reg(4'd2, 8'd100);
    RA1 = 4'd1;
    RA2 = 4'd2;
    ALUSrc = 1'b0;
    ALUControl = OP_ADD;
    #1;
    check("add_wrap", 32'(ALUResult), 32'd44);
    check("add_wrap_out", 32'(cpu_out), 32'd100);
    ALUControl = OP_SUB;
    #1;
    check("sub_rr", 32'(ALUResult), 32'd100);
    RA1 = 4'd2;
    #1;
    check("sub_self", 32'(ALUResult), 32'd0);
    check("sub_self_zero", 32'(Zero), 32'd1);

    // 5: immediate AND/OR, borrow wrap
    write_reg(4'd3, 8'hF0);
    RA1 = 4'd3;
    ALUSrc = 1'b1;
    immediate = 8'h3C;
    ALUControl = OP_AND;
    #1;
    check("and_imm", 32'(ALUResult), 32'h30);
    ALUControl = OP_OR;
    #1;
    check("or_imm", 32'(ALUResult), 32'hFC);
    RA1 = 4'd0;
    immediate = 8'd1;
    ALUControl = OP_SUB;
    #1;
    check("sub_borrow", 32'(ALUResult), 32'hFF);
    check("sub_borrow_zero", 32'(Zero), 32'd0);

    // read-during-write: old value until the edge
    RA1 = 4'd4;
    ALUSrc = 1'b1;
    immediate = 8'd10;
    ALUControl = OP_ADD;
    WA = 4'd4;
    write_enable = 1'b1;
    #1;
    check("rdw_before", 32'(ALUResult), 32'd14);
    tick();
    write_enable = 1'b0;
    check("rdw_after", 32'(ALUResult), 32'd24);

    // 6: reset wins over a simultaneous write
    RA1 = 4'd0;
    ALUSrc = 1'b1;
    immediate = 8'h99;
    ALUControl = OP_ADD;
    WA = 4'd6;
    write_enable = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    write_enable = 1'b0;
    ALUSrc = 1'b0;
    ALUControl = OP_OR;
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      RA2 = 4'(i);
      #1;
      check($sformatf("rstwr_res_%0d", i), 32'(ALUResult), 32'd0);
      check($sformatf("rstwr_out_%0d", i), 32'(cpu_out), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
